// File: rtl/full_adder_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_pkg
// Shared constants and types for the registered ripple-carry adder.
//   FULL_ADDER_DEFAULT_WIDTH : operand width used when WIDTH is not overridden
//   FULL_ADDER_MAX_WIDTH     : widest legal operand width
//   full_adder_res_t         : {cout, sum} result sized for the widest adder
// -----------------------------------------------------------------------------
package full_adder_pkg;

    localparam int FULL_ADDER_DEFAULT_WIDTH = 1;
    localparam int FULL_ADDER_MAX_WIDTH     = 64;

    typedef struct packed {
        logic                            cout;
        logic [FULL_ADDER_MAX_WIDTH-1:0] sum;
    } full_adder_res_t;

endpackage : full_adder_pkg

// File: rtl/full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
// Purely combinational one-bit full adder cell, the link of the carry chain.
// Ports:
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit      = a ^ b ^ ci
//   co   : carry out    = majority(a, b, ci)
// -----------------------------------------------------------------------------
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder_bit

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Registered WIDTH-bit ripple-carry adder. The result of in1 + in2 + cin is
// captured every rising clk edge and presented one clock later.
// Parameters:
//   WIDTH : operand width, 1..64 (anything else stops elaboration)
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (sum/cout -> 0, ovf -> 0, zero -> 1)
//   in1  : operand A, unsigned, WIDTH bits
//   in2  : operand B, unsigned, WIDTH bits
//   cin  : carry into bit 0
//   sum  : registered (in1 + in2 + cin) mod 2^WIDTH
//   cout : registered carry out of bit WIDTH-1
//   ovf  : registered two's-complement overflow   (FULL_ADDER_STATUS_EN only)
//   zero : registered flag, high when sum == 0     (FULL_ADDER_STATUS_EN only)
// Build option:
//   `define FULL_ADDER_STATUS_EN to add the ovf/zero status ports and flops.
// -----------------------------------------------------------------------------
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FULL_ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef FULL_ADDER_STATUS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    generate
        if (WIDTH < 1 || WIDTH > FULL_ADDER_MAX_WIDTH) begin : g_width_check
            $fatal(1, "full_adder: WIDTH=%0d outside legal range 1..%0d",
                   WIDTH, FULL_ADDER_MAX_WIDTH);
        end
    endgenerate

    // Carries kept as an unpacked array so each link of the chain is a
    // separate net rather than bits of one vector feeding back on itself.
    logic             carry [0:WIDTH];
    logic [WIDTH-1:0] s_next;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
            full_adder_bit u_bit (
                .a  (in1[gi]),
                .b  (in2[gi]),
                .ci (carry[gi]),
                .s  (s_next[gi]),
                .co (carry[gi+1])
            );
        end
    endgenerate

    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else begin
            sum_reg  <= s_next;
            cout_reg <= carry[WIDTH];
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

`ifdef FULL_ADDER_STATUS_EN
    logic ovf_reg;
    logic zero_reg;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    // For WIDTH = 1 the carry into the sign bit is cin itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b1;
        end else begin
            ovf_reg  <= carry[WIDTH] ^ carry[WIDTH-1];
            zero_reg <= (s_next == '0);
        end
    end

    assign ovf  = ovf_reg;
    assign zero = zero_reg;
`endif

endmodule : full_adder

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
// Drives a 1-bit and an 8-bit full_adder side by side with directed and random
// vectors; expected results come from integer arithmetic on the applied values.
// -----------------------------------------------------------------------------
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] a1, b1;
    logic       c1;
    logic [7:0] a8, b8;
    logic       c8;
    logic [0:0] sum1;
    logic       cout1;
    logic [7:0] sum8;
    logic       cout8;
`ifdef FULL_ADDER_STATUS_EN
    logic       ovf1, zero1, ovf8, zero8;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .in1  (a1),
        .in2  (b1),
        .cin  (c1),
        .sum  (sum1),
        .cout (cout1)
`ifdef FULL_ADDER_STATUS_EN
        ,
        .ovf  (ovf1),
        .zero (zero1)
`endif
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk  (clk),
        .rst  (rst),
        .in1  (a8),
        .in2  (b8),
        .cin  (c8),
        .sum  (sum8),
        .cout (cout8)
`ifdef FULL_ADDER_STATUS_EN
        ,
        .ovf  (ovf8),
        .zero (zero8)
`endif
    );

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: full-width unsigned sum, plus signed-range overflow test.
    task automatic model(input int w, input longint a, input longint b, input longint c,
                         output logic [8:0] res, output logic ovf, output logic zero);
        longint full, sa, sb, sv, span;
        span = longint'(1) << w;
        full = a + b + c;
        res  = 9'(full);
        zero = ((full % span) == 0);
        sa   = (a >= span / 2) ? a - span : a;
        sb   = (b >= span / 2) ? b - span : b;
        sv   = sa + sb + c;
        ovf  = (sv > span / 2 - 1) || (sv < -(span / 2));
    endtask

    // Apply one vector to both adders, clock it in, then check both results.
    task automatic apply(input string tag, input logic r,
                         input logic [0:0] ia1, input logic [0:0] ib1, input logic ic1,
                         input logic [7:0] ia8, input logic [7:0] ib8, input logic ic8);
        logic [8:0] e1, e8;
        logic       eo1, ez1, eo8, ez8;
        rst = r;
        a1 = ia1; b1 = ib1; c1 = ic1;
        a8 = ia8; b8 = ib8; c8 = ic8;
        model(1, longint'(ia1), longint'(ib1), longint'(ic1), e1, eo1, ez1);
        model(8, longint'(ia8), longint'(ib8), longint'(ic8), e8, eo8, ez8);
        if (r) begin
            e1 = '0; e8 = '0; eo1 = 1'b0; eo8 = 1'b0; ez1 = 1'b1; ez8 = 1'b1;
        end
        @(posedge clk);
        #1;
        $display("%-10s rst=%0d w1:%0d+%0d+%0d -> %0d%0d  w8:%02h+%02h+%0d -> %0d,%02h",
                 tag, r, ia1, ib1, ic1, cout1, sum1, ia8, ib8, ic8, cout8, sum8);
        check({tag, "_w1"}, {7'b0, cout1, sum1}, e1);
        check({tag, "_w8"}, {cout8, sum8}, e8);
`ifdef FULL_ADDER_STATUS_EN
        check({tag, "_w1_ovf"},  {8'b0, ovf1},  {8'b0, eo1});
        check({tag, "_w1_zero"}, {8'b0, zero1}, {8'b0, ez1});
        check({tag, "_w8_ovf"},  {8'b0, ovf8},  {8'b0, eo8});
        check({tag, "_w8_zero"}, {8'b0, zero8}, {8'b0, ez8});
`endif
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [2:0] v;

        // Reset held for two edges with all inputs at one.
        apply("reset0", 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        apply("reset1", 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);

        // Exhaustive 1-bit truth table; 8-bit side gets random operands.
        for (int i = 0; i < 8; i++) begin
            v  = 3'(i);
            ra = 8'($urandom);
            rb = 8'($urandom);
            apply("exhaust", 1'b0, v[2], v[1], v[0], ra, rb, v[0]);
        end

        // 8-bit boundaries: carry wrap to zero, signed overflow, full wrap.
        apply("wrap_zero", 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b1);
        apply("sgn_ovf",   1'b0, 1'b0, 1'b1, 1'b1, 8'h7F, 8'h01, 1'b0);
        apply("all_ones",  1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        apply("neg_ovf",   1'b0, 1'b1, 1'b1, 1'b0, 8'h80, 8'h80, 1'b0);

        // Mid-stream reset discards the result that would have been captured.
        apply("pre_rst",   1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 1'b1);
        apply("mid_rst",   1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0);
        apply("post_rst",  1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0);

        // Random stream, new inputs every cycle.
        for (int i = 0; i < 100; i++) begin
            v  = 3'($urandom);
            ra = 8'($urandom);
            rb = 8'($urandom);
            apply("random", 1'b0, v[2], v[1], v[0], ra, rb, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_full_adder

// File: doc/full_adder.md
# full_adder

Registered N-bit ripple-carry full adder: adds `in1`, `in2` and carry-in `cin`, and presents `sum` and `cout` from flops one clock later. It is the basic arithmetic leaf for datapath blocks. Default width 1 makes it a clocked single-bit full adder. It is driven by free-running random stimulus and its outputs are dumped to waveform.

## Interface
- `WIDTH`, default 1, operand width in bits (legal range 1–64).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset, sampled on the `clk` rising edge.
- `in1` input WIDTH: operand A, unsigned.
- `in2` input WIDTH: operand B, unsigned.
- `cin` input 1: carry-in into bit 0.
- `sum` output WIDTH: registered `(in1 + in2 + cin) mod 2^WIDTH`.
- `cout` output 1: registered carry out of bit WIDTH-1.
- `ovf` output 1, present only with `FULL_ADDER_STATUS_EN`: registered signed (two's-complement) overflow.
- `zero` output 1, present only with `FULL_ADDER_STATUS_EN`: registered flag, high when `sum` == 0.

## Operation
- Carry chain:
  - Combinational ripple of WIDTH one-bit cells.
  - Bit i: `s[i] = in1[i] ^ in2[i] ^ c[i]`.
  - Bit i: `c[i+1] = in1[i]&in2[i] | in1[i]&c[i] | in2[i]&c[i]`.
  - `c[0] = cin`.
- Output capture: on each rising `clk` with `rst` low, `sum <= s` and `cout <= c[WIDTH]`.
- Result range: `{cout, sum}` equals the full (WIDTH+1)-bit value of `in1 + in2 + cin`; maximum is `2^(WIDTH+1) - 1`.
- Wrap-around: all-ones + all-ones + 1 gives `sum` = all-ones, `cout` = 1.
- No enable, no handshake: a new result is captured every cycle.
- Reset:
  - On a rising edge with `rst` high: `sum` = 0, `cout` = 0, and, when enabled, `ovf` = 0, `zero` = 1.
  - Reset has priority over the capture.
  - Asserting reset mid-stream discards that cycle's sum.
- X handling: an unknown input propagates X only to the affected bits. No assertions are required inside the RTL.

## Timing
- Latency is exactly 1 clock: inputs sampled at edge k appear on the outputs after edge k.
- Throughput is one addition per cycle.
- Inputs must be stable around the rising edge. They may change at any other point, for example every 10 ns asynchronously to the bench.
- The critical path is the WIDTH-deep carry chain plus flop setup. No pipelining inside the chain.
- The first valid result follows the first edge with `rst` low.

## Configuration
- Macro `FULL_ADDER_STATUS_EN`.
- Defined:
  - Adds ports `ovf` and `zero`.
  - `ovf <= c[WIDTH] ^ c[WIDTH-1]`; for WIDTH = 1, `c[0]` is `cin`.
  - `zero <= (s == 0)`.
  - Both flags are registered with the same latency as `sum`.
- Not defined: the ports and their flops do not exist. `sum`/`cout` behaviour is identical in both builds.

## Structure
- Package `full_adder_pkg`:
  - `FULL_ADDER_DEFAULT_WIDTH = 1`.
  - `FULL_ADDER_MAX_WIDTH = 64`.
  - Typedef `full_adder_res_t`, a packed struct of `cout` and `sum` sized for the maximum width.
- Sub-module `full_adder_bit`: purely combinational one-bit cell with ports `a`, `b`, `ci`, `s`, `co`. It is instantiated WIDTH times in a generate loop.
- Top level holds only the generate chain, the output flops and the optional status logic.
- Elaboration check: WIDTH outside 1–64 is a fatal error.

## Test plan
- Reset: `rst` = 1 for 2 edges with inputs at 1,1,1 -> `sum` = 0, `cout` = 0 (`zero` = 1 if enabled).
- WIDTH = 1, exhaustive over all 8 combinations of `{in1, in2, cin}` from 000 to 111, one per cycle -> one edge later, `{cout, sum}` = 00, 01, 01, 10, 01, 10, 10, 11.
- WIDTH = 8:
  - `in1` = 0xFF, `in2` = 0x00, `cin` = 1 -> `sum` = 0x00, `cout` = 1, `zero` = 1.
  - `in1` = 0x7F, `in2` = 0x01, `cin` = 0 -> `sum` = 0x80, `cout` = 0, `ovf` = 1.
- Mid-stream reset: `rst` high on the edge after `in1` = 1, `in2` = 1 -> outputs 0 after that edge, no stale result.
- Random: 100 cycles of random 1-bit inputs changing every cycle; the scoreboard compares `{cout, sum}` against the previous-cycle `in1 + in2 + cin` -> zero mismatches.
